// File: rtl/mod_chk_pkg.sv
// Shared types and constants for the mod_out response checker.
package mod_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } chk_state_e;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/mod_chk_fifo.sv
// Expected-value FIFO; head word is always presented on dout.
module mod_chk_fifo #(
    parameter int OUT_WIDTH = 8,
    parameter int DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic [OUT_WIDTH-1:0] din,
    input  logic                 pop,
    output logic                 full,
    output logic                 empty,
    output logic [OUT_WIDTH-1:0] dout
);

    localparam int AW = $clog2(DEPTH);

    logic [OUT_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    // Extra pointer bit separates full from empty when indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/mod_out_checker.sv
// Compares qualified mod_out samples against queued expected values
// and reports counts, the first failure and a final pass flag.
module mod_out_checker
    import mod_chk_pkg::*;
#(
    parameter int OUT_WIDTH = 8,
    parameter int DEPTH     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 exp_valid,
    input  logic [OUT_WIDTH-1:0] exp_data,
    output logic                 exp_ready,
    input  logic                 act_valid,
    input  logic [OUT_WIDTH-1:0] act_data,
    input  logic                 start,
    input  logic [CNT_W-1:0]     expect_cnt,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CNT_W-1:0]     cmp_cnt,
    output logic [CNT_W-1:0]     err_cnt,
    output logic                 underflow,
    output logic [CNT_W-1:0]     first_err_idx,
    output logic [OUT_WIDTH-1:0] first_err_exp,
    output logic [OUT_WIDTH-1:0] first_err_act
);

    chk_state_e           state;
    chk_state_e           state_d;
    logic [CNT_W-1:0]     cnt_lat;
    logic                 full;
    logic                 empty;
    logic [OUT_WIDTH-1:0] head;
    logic                 run_start;
    logic                 cmp_en;
    logic                 miss;
    logic                 under;
    logic                 err_hit;

    mod_chk_fifo #(
        .OUT_WIDTH (OUT_WIDTH),
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (exp_valid && exp_ready),
        .din   (exp_data),
        .pop   (cmp_en && !empty),
        .full  (full),
        .empty (empty),
        .dout  (head)
    );

    assign exp_ready = !full;
    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign pass      = done && (err_cnt == '0);

    // Samples beyond the programmed count are not compared.
    assign run_start = start && (state != RUN);
    assign cmp_en    = act_valid && busy && (cmp_cnt != cnt_lat);
    assign miss      = cmp_en && !empty && (head != act_data);
    assign under     = cmp_en && empty;
    assign err_hit   = miss || under;

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE, DONE: begin
                if (start)
                    state_d = (expect_cnt == '0) ? DONE : RUN;
            end
            RUN: begin
                if (cmp_cnt == cnt_lat) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset || run_start) begin
            cnt_lat       <= reset ? '0 : expect_cnt;
            cmp_cnt       <= '0;
            err_cnt       <= '0;
            underflow     <= 1'b0;
            first_err_idx <= '0;
            first_err_exp <= '0;
            first_err_act <= '0;
        end else if (cmp_en) begin
            cmp_cnt <= cmp_cnt + 1'b1;
            if (under) underflow <= 1'b1;
            if (err_hit && err_cnt != CNT_MAX)
                err_cnt <= err_cnt + 1'b1;
            if (err_hit && err_cnt == '0) begin
                first_err_idx <= cmp_cnt;
                first_err_exp <= under ? '0 : head;
                first_err_act <= act_data;
            end
        end
    end

endmodule

// File: tb/tb_mod_out_checker.sv
// Directed self-checking bench for mod_out_checker (8-bit, 4-deep).
module tb_mod_out_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        exp_valid;
    logic [7:0]  exp_data;
    logic        exp_ready;
    logic        act_valid;
    logic [7:0]  act_data;
    logic        start;
    logic [15:0] expect_cnt;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] cmp_cnt;
    logic [15:0] err_cnt;
    logic        underflow;
    logic [15:0] first_err_idx;
    logic [7:0]  first_err_exp;
    logic [7:0]  first_err_act;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mod_out_checker #(
        .OUT_WIDTH (8),
        .DEPTH     (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .exp_valid     (exp_valid),
        .exp_data      (exp_data),
        .exp_ready     (exp_ready),
        .act_valid     (act_valid),
        .act_data      (act_data),
        .start         (start),
        .expect_cnt    (expect_cnt),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .cmp_cnt       (cmp_cnt),
        .err_cnt       (err_cnt),
        .underflow     (underflow),
        .first_err_idx (first_err_idx),
        .first_err_exp (first_err_exp),
        .first_err_act (first_err_act)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        exp_valid = 1'b1;
        exp_data  = d;
        tick();
        exp_valid = 1'b0;
    endtask

    task automatic act(input logic [7:0] d);
        act_valid = 1'b1;
        act_data  = d;
        tick();
        act_valid = 1'b0;
    endtask

    task automatic go(input logic [15:0] n);
        start      = 1'b1;
        expect_cnt = n;
        tick();
        start      = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        checks++;
        if (exp_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_ready got=%b want=1", exp_ready);
        end
        v = {busy, done, pass, underflow, 4'b0};
        checks++;
        if (v !== 8'h00) begin
            errors++;
            $display("FAIL rst_flags got=%h want=00", v);
        end
        checks++;
        if ({cmp_cnt, err_cnt, first_err_idx} !== 48'h0) begin
            errors++;
            $display("FAIL rst_cnts got=%h %h %h want=0",
                     cmp_cnt, err_cnt, first_err_idx);
        end
        checks++;
        if ({first_err_exp, first_err_act} !== 16'h0) begin
            errors++;
            $display("FAIL rst_first got=%h %h want=0",
                     first_err_exp, first_err_act);
        end
    endtask

    task automatic test_match();
        for (int i = 0; i < 3; i++) push(8'd3);
        go(16'd3);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL match_busy got=%b want=1", busy);
        end
        for (int i = 0; i < 3; i++) act(8'd3);
        checks++;
        if (cmp_cnt !== 16'd3 || done !== 1'b0) begin
            errors++;
            $display("FAIL match_lat got cmp=%0d done=%b want cmp=3 done=0",
                     cmp_cnt, done);
        end
        tick();
        checks++;
        if ({done, pass, busy} !== 3'b110 || err_cnt !== 16'd0) begin
            errors++;
            $display("FAIL match_end got dpb=%b%b%b err=%0d want 110 err=0",
                     done, pass, busy, err_cnt);
        end
    endtask

    task automatic test_mismatch();
        push(8'd1);
        push(8'd2);
        push(8'd5);
        go(16'd3);
        act(8'd1);
        act(8'd7);
        act(8'd5);
        tick();
        checks++;
        if (done !== 1'b1 || pass !== 1'b0 || err_cnt !== 16'd1) begin
            errors++;
            $display("FAIL mism_end got done=%b pass=%b err=%0d want 1 0 1",
                     done, pass, err_cnt);
        end
        checks++;
        if (first_err_idx !== 16'd1 || first_err_exp !== 8'd2 ||
            first_err_act !== 8'd7) begin
            errors++;
            $display("FAIL mism_first got=%0d/%0d/%0d want=1/2/7",
                     first_err_idx, first_err_exp, first_err_act);
        end
        checks++;
        if (underflow !== 1'b0 || cmp_cnt !== 16'd3) begin
            errors++;
            $display("FAIL mism_misc got uf=%b cmp=%0d want 0 3",
                     underflow, cmp_cnt);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) push(8'(10 + i));
        checks++;
        if (exp_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_ready got=%b want=0", exp_ready);
        end
        push(8'd14);
        checks++;
        if (exp_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_refuse got=%b want=0", exp_ready);
        end
        go(16'd2);
        exp_valid = 1'b1;
        exp_data  = 8'd15;
        act(8'd10);
        exp_valid = 1'b0;
        checks++;
        if (exp_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_pushpop got=%b want=1", exp_ready);
        end
        act(8'd11);
        tick();
        checks++;
        if (pass !== 1'b1 || err_cnt !== 16'd0) begin
            errors++;
            $display("FAIL full_run got pass=%b err=%0d want 1 0",
                     pass, err_cnt);
        end
        go(16'd2);
        act(8'd12);
        act(8'd13);
        tick();
        checks++;
        if (pass !== 1'b1 || cmp_cnt !== 16'd2) begin
            errors++;
            $display("FAIL full_drain got pass=%b cmp=%0d want 1 2",
                     pass, cmp_cnt);
        end
    endtask

    task automatic test_underflow();
        go(16'd2);
        act(8'd9);
        act(8'd9);
        tick();
        checks++;
        if (underflow !== 1'b1 || err_cnt !== 16'd2 || cmp_cnt !== 16'd2) begin
            errors++;
            $display("FAIL uf_cnt got uf=%b err=%0d cmp=%0d want 1 2 2",
                     underflow, err_cnt, cmp_cnt);
        end
        checks++;
        if (first_err_idx !== 16'd0 || first_err_exp !== 8'd0 ||
            first_err_act !== 8'd9) begin
            errors++;
            $display("FAIL uf_first got=%0d/%0d/%0d want=0/0/9",
                     first_err_idx, first_err_exp, first_err_act);
        end
        checks++;
        if (done !== 1'b1 || pass !== 1'b0) begin
            errors++;
            $display("FAIL uf_end got done=%b pass=%b want 1 0", done, pass);
        end
    endtask

    task automatic test_zero();
        logic busy_seen;
        go(16'd0);
        busy_seen = busy;
        checks++;
        if (done !== 1'b1 || pass !== 1'b1 || err_cnt !== 16'd0) begin
            errors++;
            $display("FAIL zero_end got done=%b pass=%b err=%0d want 1 1 0",
                     done, pass, err_cnt);
        end
        tick();
        busy_seen = busy_seen | busy;
        checks++;
        if (busy_seen !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL zero_busy got busy=%b done=%b want 0 1",
                     busy_seen, done);
        end
    endtask

    task automatic test_mid_reset();
        push(8'd4);
        push(8'd5);
        push(8'd6);
        go(16'd3);
        act(8'd4);
        checks++;
        if (cmp_cnt !== 16'd1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre got cmp=%0d busy=%b want 1 1",
                     cmp_cnt, busy);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({busy, done, pass} !== 3'b000 || cmp_cnt !== 16'd0 ||
            err_cnt !== 16'd0 || exp_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_clr got bdp=%b%b%b cmp=%0d err=%0d rdy=%b want 000 0 0 1",
                     busy, done, pass, cmp_cnt, err_cnt, exp_ready);
        end
        go(16'd1);
        act(8'd7);
        tick();
        checks++;
        if (underflow !== 1'b1 || first_err_act !== 8'd7 || err_cnt !== 16'd1) begin
            errors++;
            $display("FAIL mid_empty got uf=%b act=%0d err=%0d want 1 7 1",
                     underflow, first_err_act, err_cnt);
        end
    endtask

    initial begin
        reset      = 1'b1;
        exp_valid  = 1'b0;
        exp_data   = '0;
        act_valid  = 1'b0;
        act_data   = '0;
        start      = 1'b0;
        expect_cnt = '0;
        tick();
        tick();
        reset = 1'b0;
        test_reset();
        test_match();
        test_mismatch();
        test_full();
        test_underflow();
        test_zero();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
